dram_req_arbiter: RTL

Two-port arbiter and sequencer in front of the DRAM controller user interface (single-beat 128-bit read/write, `rd_en`/`wr_en` strobes, `ready`, `data_valid`). It lets two masters share the one DRAM port, for example CPU/MMU on port 0 and the display/DMA engine on port 1. It accepts one request at a time, issues exactly one command pulse to the controller, and tracks completion. It returns read data and a one-cycle done pulse to the granted master.

---
 rtl/dram_req_arbiter_if.sv | 54 +++++
 rtl/dram_req_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dram_req_arbiter_if.sv
// Bundle of both master request ports and the DRAM controller user-interface signals.
// The slave modport is the arbiter; the master modport drives requests and models the controller.
interface dram_req_arbiter_if #(
    parameter int APP_ADDR_WIDTH = 27,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16
) ();
    logic                      p0_req;
    logic                      p0_we;
    logic [APP_ADDR_WIDTH-1:0] p0_addr;
    logic [APP_DATA_WIDTH-1:0] p0_wdata;
    logic [APP_MASK_WIDTH-1:0] p0_mask;
    logic                      p0_gnt;
    logic                      p0_done;

    logic                      p1_req;
    logic                      p1_we;
    logic [APP_ADDR_WIDTH-1:0] p1_addr;
    logic [APP_DATA_WIDTH-1:0] p1_wdata;
    logic [APP_MASK_WIDTH-1:0] p1_mask;
    logic                      p1_gnt;
    logic                      p1_done;

    logic [APP_DATA_WIDTH-1:0] o_rdata;
    logic                      o_rd_en;
    logic                      o_wr_en;
    logic [APP_ADDR_WIDTH-1:0] o_addr;
    logic [APP_DATA_WIDTH-1:0] o_data;
    logic [APP_MASK_WIDTH-1:0] o_mask;
    logic                      i_ready;
    logic [APP_DATA_WIDTH-1:0] i_data;
    logic                      i_data_valid;

    // Handshake: req is a level held until done; gnt spans grant..done inclusive;
    // done is a single-cycle pulse; the controller strobes are one-cycle pulses and
    // o_addr/o_data/o_mask are only meaningful while a strobe is high.
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_mask,
        output p0_gnt, p0_done,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_mask,
        output p1_gnt, p1_done,
        output o_rdata, o_rd_en, o_wr_en, o_addr, o_data, o_mask,
        input  i_ready, i_data, i_data_valid
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_mask,
        input  p0_gnt, p0_done,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_mask,
        input  p1_gnt, p1_done,
        input  o_rdata, o_rd_en, o_wr_en, o_addr, o_data, o_mask,
        output i_ready, i_data, i_data_valid
    );
endinterface

// File: rtl/dram_req_arbiter.sv
// Two-port arbiter/sequencer for a single-beat DRAM user interface, one access outstanding.
// Define DRAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dram_req_arbiter #(
    parameter int APP_ADDR_WIDTH = 27,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_x,
    dram_req_arbiter_if.slave   bus,
    output logic [2:0]          o_dbg_state
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_GUARD = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                state_q, state_d;
    logic [1:0]                gnt_q, gnt_d;
    logic [1:0]                done_q, done_d;
    logic                      we_q, we_d;
    logic                      rd_en_q, rd_en_d;
    logic                      wr_en_q, wr_en_d;
    logic [APP_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [APP_DATA_WIDTH-1:0] data_q, data_d;
    logic [APP_MASK_WIDTH-1:0] mask_q, mask_d;
    logic [APP_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      sel1;
`ifdef DRAM_ARB_RR_EN
    logic                      rr_q, rr_d;   // 1 = port 1 preferred on a tie
`endif

`ifdef DRAM_ARB_RR_EN
    assign sel1 = bus.p1_req & (~bus.p0_req | rr_q);
`else
    assign sel1 = bus.p1_req & ~bus.p0_req;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        we_d    = we_q;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
`ifdef DRAM_ARB_RR_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if ((bus.p0_req || bus.p1_req) && bus.i_ready) begin
                    gnt_d   = sel1 ? 2'b10 : 2'b01;
                    we_d    = sel1 ? bus.p1_we    : bus.p0_we;
                    addr_d  = sel1 ? bus.p1_addr  : bus.p0_addr;
                    data_d  = sel1 ? bus.p1_wdata : bus.p0_wdata;
                    mask_d  = sel1 ? bus.p1_mask  : bus.p0_mask;
                    wr_en_d = we_d;
                    rd_en_d = ~we_d;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_GUARD;
            S_GUARD: begin
                // Ready is stale here, but early read data is genuine and must not be lost.
                if (!we_q && bus.i_data_valid) begin
                    rdata_d = bus.i_data;
                    done_d  = gnt_q;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (we_q ? bus.i_ready : bus.i_data_valid) begin
                    if (!we_q) rdata_d = bus.i_data;
                    done_d  = gnt_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = 2'b00;
`ifdef DRAM_ARB_RR_EN
                rr_d    = gnt_q[0];
`endif
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            we_q    <= 1'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
`ifdef DRAM_ARB_RR_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            we_q    <= we_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
`ifdef DRAM_ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign bus.p0_gnt  = gnt_q[0];
    assign bus.p1_gnt  = gnt_q[1];
    assign bus.p0_done = done_q[0];
    assign bus.p1_done = done_q[1];
    assign bus.o_rd_en = rd_en_q;
    assign bus.o_wr_en = wr_en_q;
    assign bus.o_addr  = addr_q;
    assign bus.o_data  = data_q;
    assign bus.o_mask  = mask_q;
    assign bus.o_rdata = rdata_q;
    assign o_dbg_state = state_q;
endmodule
